exu_wb_arb: RTL and testbench

Write-back arbiter sharing the single integer register-file write port between the single-cycle ALU and the long-latency multiply/divide unit (MDU). The ALU result arrives registered and cannot be held, so it always wins the port. MDU results wait in a small in-order buffer with a valid/ready handshake. A starvation guard stalls instruction issue so that a buffered MDU result is guaranteed to drain. The block sits between the EXU result registers and the register file, and drives the issue stall into the IDU.

---
 rtl/exu_wb_arb.sv | 167 ++++++++++++++++
 tb/tb_exu_wb_arb.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wb_arb.sv
// Write-back arbiter for the integer register-file write port.
// The ALU always wins the port. MDU results are buffered in order and drain
// when the ALU is idle. A starvation guard stalls issue so the head drains.
module exu_wb_arb #(
   parameter int XLEN       = 32,
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [XLEN-1:0]                alu_wb_data,
   input  logic [4:0]                     alu_wb_rd_addr,
   input  logic                           alu_wb_rd_wr_en,
   input  logic                           mdu_valid,
   output logic                           mdu_ready,
   input  logic [XLEN-1:0]                mdu_data,
   input  logic [4:0]                     mdu_rd_addr,
   output logic                           rf_wr_en,
   output logic [4:0]                     rf_wr_addr,
   output logic [XLEN-1:0]                rf_wr_data,
   output logic                           rf_wr_src,
   output logic                           issue_stall,
   output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   // Circular buffer storage; only slots between head and tail are meaningful.
   logic [XLEN-1:0]      data_q [BUF_DEPTH];
   logic [4:0]           rd_q   [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] dead_q, dead_d;
   logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [SW-1:0]        starve_q, starve_d;
   state_t               state_q, state_d;

   logic                 wr_en_q, wr_en_d, wr_src_q, wr_src_d;
   logic [4:0]           wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]      wr_data_q, wr_data_d;

   logic alu_win, buf_empty, xfer, mdu_live, head_live, head_dead;
   logic grant_head, bypass, pop, push, push_dead;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // ALU writes to x0 neither take the port nor kill buffered entries.
   assign alu_win    = alu_wb_rd_wr_en && (alu_wb_rd_addr != 5'd0);
   assign buf_empty  = (count_q == '0);
   // Ready depends on registered occupancy only, never on this cycle's pop.
   assign mdu_ready  = (count_q < CW'(BUF_DEPTH));
   assign xfer       = mdu_valid && mdu_ready;
   assign mdu_live   = xfer && (mdu_rd_addr != 5'd0);
   assign head_live  = !buf_empty && !dead_q[head_q];
   assign head_dead  = !buf_empty && dead_q[head_q];
   assign grant_head = !alu_win && head_live;
   assign bypass     = !alu_win && buf_empty && mdu_live;
   assign pop        = grant_head || head_dead;
   assign push       = mdu_live && !bypass;
   // An arriving result already overwritten by the younger ALU write is dead.
   assign push_dead  = alu_win && (mdu_rd_addr == alu_wb_rd_addr);

   generate
      for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_dead
         assign dead_d[gi] = (push && (tail_q == PW'(gi))) ? push_dead :
                             (dead_q[gi] || (alu_win && (rd_q[gi] == alu_wb_rd_addr)));
      end
   endgenerate

   // Pointer and occupancy update for at most one push and one pop per cycle.
   always_comb begin
      head_d  = pop  ? wrap_inc(head_q) : head_q;
      tail_d  = push ? wrap_inc(tail_q) : tail_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Starvation counter and RUN/STALL next state.
   always_comb begin
      starve_d = starve_q;
      state_d  = state_q;
      if (pop || buf_empty) begin
         starve_d = '0;
      end else if (head_live && alu_win && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
      case (state_q)
         RUN:     if (!pop && (starve_q == SW'(STARVE_MAX))) state_d = STALL;
         STALL:   if (pop) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Port grant: ALU, then live head, then bypass; address/data hold when idle.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_src_d  = wr_src_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (alu_win) begin
         wr_en_d   = 1'b1;
         wr_src_d  = 1'b0;
         wr_addr_d = alu_wb_rd_addr;
         wr_data_d = alu_wb_data;
      end else if (grant_head) begin
         wr_en_d   = 1'b1;
         wr_src_d  = 1'b1;
         wr_addr_d = rd_q[head_q];
         wr_data_d = data_q[head_q];
      end else if (bypass) begin
         wr_en_d   = 1'b1;
         wr_src_d  = 1'b1;
         wr_addr_d = mdu_rd_addr;
         wr_data_d = mdu_data;
      end
   end

   // Control state, destinations and registered write-port outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         dead_q    <= '0;
         starve_q  <= '0;
         state_q   <= RUN;
         wr_en_q   <= 1'b0;
         wr_src_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) rd_q[i] <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         dead_q    <= dead_d;
         starve_q  <= starve_d;
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_src_q  <= wr_src_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         if (push) rd_q[tail_q] <= mdu_rd_addr;
      end
   end

   // Result data storage; written only on push, read only for valid slots.
   always_ff @(posedge clk) begin
      if (push) data_q[tail_q] <= mdu_data;
   end

   assign rf_wr_en    = wr_en_q;
   assign rf_wr_addr  = wr_addr_q;
   assign rf_wr_data  = wr_data_q;
   assign rf_wr_src   = wr_src_q;
   assign issue_stall = (state_q == STALL);
   assign buf_count   = count_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Testbench for exu_wb_arb: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_exu_wb_arb;
   localparam int XLEN       = 32;
   localparam int BUF_DEPTH  = 2;
   localparam int STARVE_MAX = 8;
   localparam int CW         = $clog2(BUF_DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] alu_wb_data, mdu_data, rf_wr_data;
   logic [4:0]      alu_wb_rd_addr, mdu_rd_addr, rf_wr_addr;
   logic            alu_wb_rd_wr_en, mdu_valid, mdu_ready;
   logic            rf_wr_en, rf_wr_src, issue_stall;
   logic [CW-1:0]   buf_count;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      bit              dead;
   } ent_t;

   // Reference model state: pending MDU results, oldest first.
   ent_t            mq[$];
   int              m_starve;
   bit              m_stall;
   bit              m_en;
   bit              m_src;
   logic [4:0]      m_addr;
   logic [XLEN-1:0] m_data;

   always #5 clk = ~clk;

   exu_wb_arb #(.XLEN(XLEN), .BUF_DEPTH(BUF_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk            (clk),
      .rst            (rst),
      .alu_wb_data    (alu_wb_data),
      .alu_wb_rd_addr (alu_wb_rd_addr),
      .alu_wb_rd_wr_en(alu_wb_rd_wr_en),
      .mdu_valid      (mdu_valid),
      .mdu_ready      (mdu_ready),
      .mdu_data       (mdu_data),
      .mdu_rd_addr    (mdu_rd_addr),
      .rf_wr_en       (rf_wr_en),
      .rf_wr_addr     (rf_wr_addr),
      .rf_wr_data     (rf_wr_data),
      .rf_wr_src      (rf_wr_src),
      .issue_stall    (issue_stall),
      .buf_count      (buf_count)
   );

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
      m_en     = 0;
      m_src    = 0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic idle();
      alu_wb_rd_wr_en = 1'b0;
      alu_wb_rd_addr  = '0;
      alu_wb_data     = '0;
      mdu_valid       = 1'b0;
      mdu_rd_addr     = '0;
      mdu_data        = '0;
   endtask

   // Advance the model by one cycle for the current inputs, then clock the DUT.
   task automatic tick();
      bit alu_w, live_head, pop, xfer, byp;
      alu_w     = alu_wb_rd_wr_en && (alu_wb_rd_addr != 0);
      xfer      = mdu_valid && (mq.size() < BUF_DEPTH);
      live_head = (mq.size() > 0) && !mq[0].dead;
      pop = 0; byp = 0; m_en = 0;
      if (alu_w) begin
         m_en = 1; m_src = 0; m_addr = alu_wb_rd_addr; m_data = alu_wb_data;
      end else if (live_head) begin
         m_en = 1; m_src = 1; m_addr = mq[0].rd; m_data = mq[0].data; pop = 1;
      end else if (xfer && mdu_rd_addr != 0 && mq.size() == 0) begin
         m_en = 1; m_src = 1; m_addr = mdu_rd_addr; m_data = mdu_data; byp = 1;
      end
      if (mq.size() > 0 && mq[0].dead) pop = 1;
      if (pop) m_stall = 0;
      else if (m_starve == STARVE_MAX) m_stall = 1;
      if (pop || mq.size() == 0) m_starve = 0;
      else if (live_head && alu_w && m_starve < STARVE_MAX) m_starve++;
      if (alu_w) foreach (mq[i]) if (mq[i].rd == alu_wb_rd_addr) mq[i].dead = 1;
      if (pop) void'(mq.pop_front());
      if (xfer && mdu_rd_addr != 0 && !byp)
         mq.push_back('{mdu_rd_addr, mdu_data, alu_w && (mdu_rd_addr == alu_wb_rd_addr)});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (rf_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got=%b exp=0", rf_wr_en); end
      vectors++; if (rf_wr_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", rf_wr_addr); end
      vectors++; if (rf_wr_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", rf_wr_data); end
      vectors++; if (rf_wr_src !== 1'b0) begin miscompares++; $display("FAIL reset_src got=%b exp=0", rf_wr_src); end
      vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", issue_stall); end
      vectors++; if (buf_count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", buf_count); end
      vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", mdu_ready); end
      $display("test_reset done");
   endtask

   task automatic test_alu_only();
      do_reset();
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd5; alu_wb_data = 32'h1234_5678;
      tick();
      idle();
      vectors++; if (rf_wr_en !== 1'b1) begin miscompares++; $display("FAIL alu_en got=%b exp=1", rf_wr_en); end
      vectors++; if (rf_wr_addr !== 5'd5) begin miscompares++; $display("FAIL alu_addr got=%0d exp=5", rf_wr_addr); end
      vectors++; if (rf_wr_data !== 32'h1234_5678) begin miscompares++; $display("FAIL alu_data got=%h exp=12345678", rf_wr_data); end
      vectors++; if (rf_wr_src !== 1'b0) begin miscompares++; $display("FAIL alu_src got=%b exp=0", rf_wr_src); end
      vectors++; if (buf_count !== '0) begin miscompares++; $display("FAIL alu_count got=%0d exp=0", buf_count); end
      // x0 write is dropped; previous address and data are held
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd0; alu_wb_data = 32'hFFFF_0000;
      tick();
      idle();
      vectors++; if (rf_wr_en !== 1'b0) begin miscompares++; $display("FAIL alu_x0_en got=%b exp=0", rf_wr_en); end
      vectors++; if (rf_wr_data !== 32'h1234_5678) begin miscompares++; $display("FAIL alu_hold_data got=%h exp=12345678", rf_wr_data); end
      $display("test_alu_only done");
   endtask

   task automatic test_bypass_vs_buffer();
      do_reset();
      mdu_valid = 1'b1; mdu_rd_addr = 5'd7; mdu_data = 32'hDEAD_BEEF;
      tick();
      idle();
      vectors++; if (rf_wr_en !== 1'b1 || rf_wr_src !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL bypass got en=%b src=%b addr=%0d data=%h exp en=1 src=1 addr=7 data=deadbeef", rf_wr_en, rf_wr_src, rf_wr_addr, rf_wr_data); end
      vectors++; if (buf_count !== '0) begin miscompares++; $display("FAIL bypass_count got=%0d exp=0", buf_count); end
      mdu_valid = 1'b1; mdu_rd_addr = 5'd7; mdu_data = 32'hDEAD_BEEF;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd3; alu_wb_data = 32'h0000_0333;
      tick();
      idle();
      vectors++; if (rf_wr_en !== 1'b1 || rf_wr_src !== 1'b0 || rf_wr_addr !== 5'd3) begin
         miscompares++; $display("FAIL buffer_alu got en=%b src=%b addr=%0d exp en=1 src=0 addr=3", rf_wr_en, rf_wr_src, rf_wr_addr); end
      vectors++; if (buf_count !== CW'(1)) begin miscompares++; $display("FAIL buffer_count got=%0d exp=1", buf_count); end
      tick();
      vectors++; if (rf_wr_en !== 1'b1 || rf_wr_src !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL buffer_drain got en=%b src=%b addr=%0d data=%h exp en=1 src=1 addr=7 data=deadbeef", rf_wr_en, rf_wr_src, rf_wr_addr, rf_wr_data); end
      vectors++; if (buf_count !== '0) begin miscompares++; $display("FAIL buffer_drain_count got=%0d exp=0", buf_count); end
      $display("test_bypass_vs_buffer done");
   endtask

   task automatic test_full();
      logic [4:0] rds [3];
      int         accepted;
      int         order[$];
      bit         took;
      rds = '{5'd10, 5'd11, 5'd12};
      accepted = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = $urandom;
         mdu_valid = (accepted < 3);
         if (accepted < 3) begin mdu_rd_addr = rds[accepted]; mdu_data = 32'hA000_0000 + accepted; end
         took = mdu_valid && mdu_ready;
         tick();
         if (took) accepted++;
      end
      vectors++; if (accepted != 2) begin miscompares++; $display("FAIL full_accepted got=%0d exp=2", accepted); end
      vectors++; if (buf_count !== CW'(2)) begin miscompares++; $display("FAIL full_count got=%0d exp=2", buf_count); end
      vectors++; if (mdu_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got=%b exp=0", mdu_ready); end
      alu_wb_rd_wr_en = 1'b0;
      for (int c = 0; c < 6; c++) begin
         mdu_valid = (accepted < 3);
         if (accepted < 3) begin mdu_rd_addr = rds[accepted]; mdu_data = 32'hA000_0000 + accepted; end
         took = mdu_valid && mdu_ready;
         tick();
         if (took) accepted++;
         if (rf_wr_en === 1'b1 && rf_wr_src === 1'b1) order.push_back(int'(rf_wr_addr));
         vectors++; if (rf_wr_en !== m_en || rf_wr_data !== m_data) begin
            miscompares++; $display("FAIL full_drain cyc=%0d got en=%b data=%h exp en=%b data=%h", c, rf_wr_en, rf_wr_data, m_en, m_data); end
      end
      vectors++; if (order.size() != 3) begin miscompares++; $display("FAIL full_order_len got=%0d exp=3", order.size()); end
      for (int i = 0; i < 3 && i < order.size(); i++) begin
         vectors++; if (order[i] != int'(rds[i])) begin miscompares++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, order[i], rds[i]); end
      end
      idle();
      $display("test_full done");
   endtask

   task automatic test_starvation();
      int waited;
      do_reset();
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = $urandom;
      mdu_valid = 1'b1; mdu_rd_addr = 5'd20; mdu_data = 32'h0000_5A5A;
      tick();
      mdu_valid = 1'b0;
      waited = 0;
      while (issue_stall !== 1'b1 && waited < 30) begin
         alu_wb_data = $urandom;
         tick();
         waited++;
      end
      vectors++; if (waited != STARVE_MAX + 1) begin miscompares++; $display("FAIL starve_latency got=%0d exp=%0d", waited, STARVE_MAX + 1); end
      vectors++; if (buf_count !== CW'(1)) begin miscompares++; $display("FAIL starve_count got=%0d exp=1", buf_count); end
      idle();
      tick();
      vectors++; if (rf_wr_en !== 1'b1 || rf_wr_src !== 1'b1 || rf_wr_addr !== 5'd20 || rf_wr_data !== 32'h0000_5A5A) begin
         miscompares++; $display("FAIL starve_drain got en=%b src=%b addr=%0d data=%h exp en=1 src=1 addr=20 data=00005a5a", rf_wr_en, rf_wr_src, rf_wr_addr, rf_wr_data); end
      vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL starve_release got=%b exp=0", issue_stall); end
      $display("test_starvation done");
   endtask

   task automatic test_waw();
      do_reset();
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'h0;
      mdu_valid = 1'b1; mdu_rd_addr = 5'd9; mdu_data = 32'h0000_1111;
      tick();
      mdu_valid = 1'b0;
      alu_wb_rd_addr = 5'd9; alu_wb_data = 32'h0000_2222;
      tick();
      idle();
      vectors++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd9 || rf_wr_data !== 32'h0000_2222 || rf_wr_src !== 1'b0) begin
         miscompares++; $display("FAIL waw_alu got en=%b addr=%0d data=%h src=%b exp en=1 addr=9 data=00002222 src=0", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_src); end
      tick();
      vectors++; if (rf_wr_en !== 1'b0) begin miscompares++; $display("FAIL waw_dead_pop_en got=%b exp=0", rf_wr_en); end
      vectors++; if (buf_count !== '0) begin miscompares++; $display("FAIL waw_count got=%0d exp=0", buf_count); end
      tick();
      vectors++; if (rf_wr_en !== 1'b0 || rf_wr_data !== 32'h0000_2222) begin
         miscompares++; $display("FAIL waw_no_stale got en=%b data=%h exp en=0 data=00002222", rf_wr_en, rf_wr_data); end
      $display("test_waw done");
   endtask

   task automatic test_async_reset();
      int waited;
      do_reset();
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1;
      mdu_valid = 1'b1; mdu_rd_addr = 5'd20; mdu_data = 32'h1;
      tick();
      mdu_rd_addr = 5'd21; mdu_data = 32'h2;
      tick();
      mdu_valid = 1'b0;
      waited = 0;
      while (issue_stall !== 1'b1 && waited < 30) begin
         alu_wb_data = $urandom;
         tick();
         waited++;
      end
      vectors++; if (buf_count !== CW'(2) || issue_stall !== 1'b1) begin
         miscompares++; $display("FAIL areset_setup got count=%0d stall=%b exp count=2 stall=1", buf_count, issue_stall); end
      idle();
      #3;
      rst = 1'b1;
      #1;
      vectors++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== '0 || rf_wr_src !== 1'b0) begin
         miscompares++; $display("FAIL areset_rf got en=%b addr=%0d data=%h src=%b exp all 0", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_src); end
      vectors++; if (issue_stall !== 1'b0 || buf_count !== '0 || mdu_ready !== 1'b1) begin
         miscompares++; $display("FAIL areset_ctl got stall=%b count=%0d ready=%b exp 0 0 1", issue_stall, buf_count, mdu_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++; if (rf_wr_en !== 1'b0 || buf_count !== '0) begin
            miscompares++; $display("FAIL areset_stale cyc=%0d got en=%b count=%0d exp en=0 count=0", c, rf_wr_en, buf_count); end
      end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      int alu_pct;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         alu_pct = (c < 200) ? 60 : 90;
         alu_wb_rd_wr_en = ($urandom_range(0, 99) < alu_pct);
         alu_wb_rd_addr  = 5'($urandom_range(0, 7));
         alu_wb_data     = $urandom;
         mdu_valid       = 1'($urandom_range(0, 1));
         mdu_rd_addr     = 5'($urandom_range(0, 7));
         mdu_data        = $urandom;
         tick();
         vectors++; if (rf_wr_en !== m_en) begin miscompares++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", c, rf_wr_en, m_en); end
         vectors++; if (rf_wr_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", c, rf_wr_addr, m_addr); end
         vectors++; if (rf_wr_data !== m_data) begin miscompares++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, rf_wr_data, m_data); end
         vectors++; if (rf_wr_src !== m_src) begin miscompares++; $display("FAIL rnd_src cyc=%0d got=%b exp=%b", c, rf_wr_src, m_src); end
         vectors++; if (buf_count !== CW'(mq.size())) begin miscompares++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, buf_count, mq.size()); end
         vectors++; if (issue_stall !== m_stall) begin miscompares++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, issue_stall, m_stall); end
         vectors++; if (mdu_ready !== (mq.size() < BUF_DEPTH)) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, mdu_ready, mq.size() < BUF_DEPTH); end
      end
      idle();
      $display("test_random done");
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      test_reset();
      test_alu_only();
      test_bypass_vs_buffer();
      test_full();
      test_starvation();
      test_waw();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
